// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one single-byte i2c_master among N requesters,
// with a watchdog that aborts a transaction the master never completes.
module i2c_req_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_req,
    input  logic [N-1:0]   i_req_rw,
    input  logic [7*N-1:0] i_req_addr,
    input  logic [8*N-1:0] i_req_wdata,
    output logic [N-1:0]   o_gnt,
    output logic [N-1:0]   o_rsp_valid,
    output logic [7:0]     o_rsp_rdata,
    output logic           o_rsp_err,
    output logic           o_m_start,
    output logic           o_m_rw,
    output logic [6:0]     o_m_addr,
    output logic [7:0]     o_m_tx_byte,
    input  logic [7:0]     i_m_rx_byte,
    input  logic           i_m_busy,
    input  logic           i_m_done
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state, w_next;
    logic [IW-1:0] r_last, w_win, w_idx;
    logic [CW-1:0] r_cnt;
    logic          w_found, w_grant, w_tmo;
    logic          w_rw;
    logic [6:0]    w_addr;
    logic [7:0]    w_wdata;

    // Offsets are walked farthest-first so the nearest requester after r_last is the last write.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = N; i >= 1; i--) begin
            w_idx = IW'((int'(r_last) + i) % N);
            if (i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_rw    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win == IW'(i)) begin
                w_rw    = i_req_rw[i];
                w_addr  = i_req_addr[7*i +: 7];
                w_wdata = i_req_wdata[8*i +: 8];
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && w_found && !i_m_busy;
    assign w_tmo   = (r_cnt == CW'(TIMEOUT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_grant ? S_WAIT : S_IDLE;
            S_WAIT:  w_next = (i_m_done || w_tmo) ? S_RESP : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_gnt       <= '0;
            o_rsp_valid <= '0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_m_start   <= 1'b0;
            o_m_rw      <= 1'b0;
            o_m_addr    <= '0;
            o_m_tx_byte <= '0;
            r_last      <= IW'(N - 1);
            r_cnt       <= '0;
        end else begin
            o_gnt       <= '0;
            o_rsp_valid <= '0;
            o_m_start   <= 1'b0;
            if (w_grant) begin
                o_gnt       <= N'(1) << w_win;
                o_m_start   <= 1'b1;
                o_m_rw      <= w_rw;
                o_m_addr    <= w_addr;
                o_m_tx_byte <= w_wdata;
                r_last      <= w_win;
                r_cnt       <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
                // a done arriving in the same cycle as the timeout still counts as success
                if (i_m_done || w_tmo) begin
                    o_rsp_valid <= N'(1) << r_last;
                    o_rsp_rdata <= i_m_done ? i_m_rx_byte : 8'h00;
                    o_rsp_err   <= !i_m_done;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: random requesters and master against a transaction-level
// model of grant order, response timing, watchdog and reset.
module tb_i2c_req_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]   req = '0, req_rw = '0;
    logic [7*N-1:0] req_addr = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic [N-1:0]   gnt, rsp_valid;
    logic [7:0]     rsp_rdata, m_tx_byte;
    logic           rsp_err, m_start, m_rw;
    logic [6:0]     m_addr;
    logic [7:0]     m_rx_byte = '0;
    logic           m_busy = 1'b0, m_done = 1'b0;

    i2c_req_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req(req), .i_req_rw(req_rw), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_gnt(gnt), .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_m_start(m_start), .o_m_rw(m_rw), .o_m_addr(m_addr), .o_m_tx_byte(m_tx_byte),
        .i_m_rx_byte(m_rx_byte), .i_m_busy(m_busy), .i_m_done(m_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, last = N - 1, g_cyc = 0, done_at = -1, avail_from = 0, win = 0;
    bit outst = 1'b0;
    int off [N];
    logic [N-1:0]   p_req = '0, p_rw = '0;
    logic [7*N-1:0] p_addr = '0;
    logic [8*N-1:0] p_wdata = '0;
    logic           p_busy = 1'b0, p_done = 1'b0;
    logic [7:0]     p_rx = '0, cur_rx = '0, e_tx = '0;
    logic [6:0]     e_addr = '0;
    logic           e_rw = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_gnt"}, gnt, 0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 0);
        chk({pfx, "_rsp_rdata"}, rsp_rdata, 0);
        chk({pfx, "_rsp_err"}, rsp_err, 0);
        chk({pfx, "_m_start"}, m_start, 0);
        chk({pfx, "_m_rw"}, m_rw, 0);
        chk({pfx, "_m_addr"}, m_addr, 0);
        chk({pfx, "_m_tx_byte"}, m_tx_byte, 0);
    endtask

    function automatic int rr(input logic [N-1:0] r, input int l);
        for (int k = 1; k <= N; k++)
            if (r[(l + k) % N]) return (l + k) % N;
        return -1;
    endfunction

    task automatic latch_inputs();
        p_req = req; p_rw = req_rw; p_addr = req_addr; p_wdata = req_wdata;
        p_busy = m_busy; p_done = m_done; p_rx = m_rx_byte;
    endtask

    task automatic step();
        logic [N-1:0] exp_gnt, exp_rsp;
        int w;
        @(negedge clk);
        cyc++;
        exp_rsp = '0;
        if (outst && cyc > g_cyc) begin
            if (p_done && cyc - 1 <= g_cyc + TO) begin
                exp_rsp[win] = 1'b1;
                chk("rsp_rdata", rsp_rdata, p_rx);
                chk("rsp_err_done", rsp_err, 0);
            end else if (cyc == g_cyc + TO + 1) begin
                exp_rsp[win] = 1'b1;
                chk("rsp_rdata_tmo", rsp_rdata, 0);
                chk("rsp_err_tmo", rsp_err, 1);
            end
        end
        chk("rsp_valid", rsp_valid, exp_rsp);
        if (exp_rsp != 0) begin
            outst = 1'b0;
            avail_from = cyc + 1;
            off[win] = $urandom_range(0, 3);
        end
        exp_gnt = '0;
        if (!outst && cyc - 1 >= avail_from && p_req != 0 && !p_busy) begin
            w = rr(p_req, last);
            exp_gnt[w] = 1'b1;
            last = w; win = w; outst = 1'b1; g_cyc = cyc;
            e_rw = p_rw[w]; e_addr = p_addr[7*w +: 7]; e_tx = p_wdata[8*w +: 8];
        end
        chk("gnt", gnt, exp_gnt);
        chk("m_start", m_start, exp_gnt != 0);
        chk("m_rw", m_rw, e_rw);
        chk("m_addr", m_addr, e_addr);
        chk("m_tx_byte", m_tx_byte, e_tx);
        if (m_start) begin
            cur_rx = 8'($urandom);
            case ($urandom_range(0, 9))
                0:       done_at = -1;
                1:       done_at = cyc + TO;
                2:       done_at = cyc + TO + 1;
                default: done_at = cyc + $urandom_range(0, 5);
            endcase
        end
        m_done    = (cyc == done_at) || (!outst && $urandom_range(0, 15) == 0);
        m_rx_byte = (cyc == done_at) ? cur_rx : 8'($urandom);
        if (cyc == done_at) done_at = -1;
        m_busy = ($urandom_range(0, 4) == 0);
        for (int i = 0; i < N; i++) begin
            if (off[i] > 0) begin
                req[i] = 1'b0;
                off[i]--;
            end else if (!req[i]) begin
                if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    req_rw[i] = 1'($urandom);
                    req_addr[7*i +: 7] = 7'($urandom);
                    req_wdata[8*i +: 8] = 8'($urandom);
                end
            end else if (outst && win == i) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_rw[i] = 1'($urandom);
                    req_addr[7*i +: 7] = 7'($urandom);
                    req_wdata[8*i +: 8] = 8'($urandom);
                end
                if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                req[i] = 1'b0;
            end
        end
        latch_inputs();
    endtask

    task automatic reset_mid();
        int k = 0;
        while (!(outst && cyc > g_cyc + 1) && k < 300) begin
            step();
            k++;
        end
        chk("wait_grant_budget", k < 300, 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_async");
        req = '1; m_busy = 1'b0; m_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_rsp_valid", rsp_valid, 0);
            chk("rst_hold_gnt", gnt, 0);
        end
        rst_n = 1'b1;
        last = N - 1; outst = 1'b0; done_at = -1; avail_from = cyc;
        e_rw = 1'b0; e_addr = '0; e_tx = '0;
        for (int i = 0; i < N; i++) off[i] = 0;
        latch_inputs();
        step();
        chk("first_gnt_after_rst", gnt, 1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) off[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        latch_inputs();
        repeat (1500) step();
        reset_mid();
        repeat (1500) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
